spi_tx_master: RTL and testbench

//  SPI mode-0 master transmitter: the host-side counterpart of the SPI receive slave.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_clk_div.sv | 30 +++
 rtl/spi_tx_master.sv | 172 +++++++++++++++++
 tb/tb_spi_tx_master.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: FSM encoding and SPI mode constants shared by the transmit master
// and the receive slave.
package spi_pkg;

  localparam int SPI_BITS = 8;

  localparam logic CPOL      = 1'b0;
  localparam logic CPHA      = 1'b0;
  localparam logic MSB_FIRST = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_GAP,
    ST_TAIL,
    ST_GUARD
  } state_e;

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: loadable half-period down-counter; o_tick is high while the
// count sits at zero, i.e. on the last cycle of each SCK phase.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values, independent of the order blocks are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(CLK_DIV - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/spi_tx_master.sv
// spi_tx_master: SPI mode-0 master transmitter, MSB first, SSEL active low.
// Define SPI_TX_MISO_CAPTURE_EN to add MISO capture (rx_data/rx_valid).
module spi_tx_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GUARD   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SPI_BITS-1:0] tx_data,
  input  logic                tx_valid,
  input  logic                tx_last,
  output logic                tx_ready,
  output logic                busy,
  output logic                SCK,
  output logic                MOSI,
  output logic                SSEL,
`ifdef SPI_TX_MISO_CAPTURE_EN
  output logic [SPI_BITS-1:0] rx_data,
  output logic                rx_valid,
`endif
  input  logic                MISO
);

  localparam int              BW       = $clog2(SPI_BITS);
  localparam logic [BW-1:0]   LAST_BIT = BW'(SPI_BITS - 1);
  localparam int              GW       = (GUARD > 1) ? $clog2(GUARD) : 1;

  state_e              r_state;
  logic [SPI_BITS-1:0] r_shift;
  logic [BW-1:0]       r_bit_cnt;
  logic [GW-1:0]       r_guard_cnt;
  logic                r_last;
  logic                r_sck;
  logic                r_mosi;
  logic                r_ssel;
  logic                r_tx_ready;
  logic                r_busy;

  logic w_accept;
  logic w_tick;
  logic w_load;

  assign w_accept = tx_valid && r_tx_ready;

  // NOTE: the reload is decoded combinationally so the counter restarts on
  // the same edge the FSM changes phase, not one cycle late.
  assign w_load = w_accept ||
                  (w_tick && (r_state == ST_LO || r_state == ST_HI));

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_guard_cnt <= '0;
      r_last      <= 1'b0;
      r_sck       <= CPOL;
      r_mosi      <= 1'b0;
      r_ssel      <= 1'b1;
      r_tx_ready  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_GAP: begin
          r_tx_ready <= 1'b1;
          if (w_accept) begin
            r_shift    <= tx_data;
            r_last     <= tx_last;
            r_mosi     <= tx_data[SPI_BITS-1];
            r_bit_cnt  <= '0;
            r_ssel     <= 1'b0;
            r_busy     <= 1'b1;
            r_tx_ready <= 1'b0;
            r_state    <= ST_LO;
          end
        end

        ST_LO: begin
          if (w_tick) begin
            r_sck   <= ~CPOL;
            r_state <= ST_HI;
          end
        end

        ST_HI: begin
          if (w_tick) begin
            r_sck     <= CPOL;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt != LAST_BIT) begin
              r_shift <= r_shift << 1;
              r_mosi  <= r_shift[SPI_BITS-2];
              r_state <= ST_LO;
            end else if (r_last) begin
              r_state <= ST_TAIL;
            end else begin
              r_tx_ready <= 1'b1;
              r_state    <= ST_GAP;
            end
          end
        end

        ST_TAIL: begin
          if (w_tick) begin
            r_ssel      <= 1'b1;
            r_guard_cnt <= GW'(GUARD - 1);
            r_state     <= ST_GUARD;
          end
        end

        ST_GUARD: begin
          if (r_guard_cnt == '0) begin
            r_busy     <= 1'b0;
            r_tx_ready <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_guard_cnt <= r_guard_cnt - 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_ready = r_tx_ready;
  assign busy     = r_busy;
  assign SCK      = r_sck;
  assign MOSI     = r_mosi;
  assign SSEL     = r_ssel;

`ifdef SPI_TX_MISO_CAPTURE_EN
  logic [SPI_BITS-1:0] r_rx_shift;
  logic [SPI_BITS-1:0] r_rx_data;
  logic                r_rx_valid;

  // MISO is taken on the edge that raises SCK; the byte is published with the 8th fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (r_state == ST_LO && w_tick) begin
        r_rx_shift <= {r_rx_shift[SPI_BITS-2:0], MISO};
      end
      if (r_state == ST_HI && w_tick && r_bit_cnt == LAST_BIT) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
`else
  logic w_unused_miso;
  assign w_unused_miso = MISO;
`endif

endmodule

// File: tb/tb_spi_tx_master.sv
// tb_spi_tx_master: directed self-checking bench for spi_tx_master
// (CLK_DIV=4, GUARD=4); MISO capture checks run with SPI_TX_MISO_CAPTURE_EN.
module tb_spi_tx_master;

  localparam int CLK_DIV = 4;
  localparam int GUARD   = 4;
  localparam int BOUND   = 3000;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last  = 1'b0;
  logic       tx_ready;
  logic       busy;
  logic       SCK;
  logic       MOSI;
  logic       SSEL;
  logic       MISO;
`ifdef SPI_TX_MISO_CAPTURE_EN
  logic [7:0] rx_data;
  logic       rx_valid;
`endif

  int n_cmp = 0;
  int n_err = 0;

  spi_tx_master #(
    .CLK_DIV (CLK_DIV),
    .GUARD   (GUARD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .busy     (busy),
    .SCK      (SCK),
    .MOSI     (MOSI),
    .SSEL     (SSEL),
`ifdef SPI_TX_MISO_CAPTURE_EN
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
`endif
    .MISO     (MISO)
  );

  always #5 clk = ~clk;

  // Bus monitor acting as the loopback slave: MOSI bits, SCK low times, SSEL edges.
  logic bit_q[$];
  int   low_q[$];
  int   rises      = 0;
  int   ssel_falls = 0;
  int   ssel_rises = 0;
  time  t_fall     = 0;

  always @(posedge SCK) begin
    bit_q.push_back(MOSI);
    low_q.push_back(int'(($time - t_fall) / 10));
    rises++;
  end
  always @(negedge SCK)  t_fall = $time;
  always @(negedge SSEL) ssel_falls++;
  always @(posedge SSEL) ssel_rises++;

  logic [7:0] miso_pat  = 8'h00;
  int         miso_base = 0;
  assign MISO = miso_pat[3'(7 - ((rises - miso_base) % 8))];

  logic sck_h  [1:80];
  logic ssel_h [1:80];
  logic rdy_h  [1:80];
  logic busy_h [1:80];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] get_byte(input int idx);
    logic [7:0] b = 8'h00;
    for (int i = 0; i < 8; i++) b = {b[6:0], bit_q[idx+i]};
    return b;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (tx_ready !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_timeout"}, 32'(n < BOUND), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(tx_ready === 1'b1 && busy === 1'b0) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(n < BOUND), 32'd1);
  endtask

  // Returns at the first negedge after the accepting clock edge.
  task automatic send(input logic [7:0] d, input logic last, input string tag);
    @(negedge clk);
    tx_data  = d;
    tx_last  = last;
    tx_valid = 1'b1;
    wait_ready(tag);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_rises(input int target, input string tag);
    int n = 0;
    while (rises < target && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rise_timeout"}, 32'(n < BOUND), 32'd1);
  endtask

  initial begin
    int base;
    int sf;
    int sr;
    int viol;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sck",   SCK,      1'b0);
    check("rst_mosi",  MOSI,     1'b0);
    check("rst_ssel",  SSEL,     1'b1);
    check("rst_ready", tx_ready, 1'b0);
    check("rst_busy",  busy,     1'b0);
`ifdef SPI_TX_MISO_CAPTURE_EN
    check("rst_rx_data",  rx_data,  8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
`endif
    rst = 1'b0;
    #1 check("rel_ready_before_clk", tx_ready, 1'b0);
    @(negedge clk);
    check("rel_ready", tx_ready, 1'b1);
    check("rel_ssel",  SSEL,     1'b1);

    // 1: single byte A5, cycle-exact timing relative to accept
    base = rises;
    send(8'hA5, 1'b1, "t1");
    check("t1_ssel_k1",  SSEL,     1'b0);
    check("t1_mosi_k1",  MOSI,     1'b1);
    check("t1_ready_k1", tx_ready, 1'b0);
    for (int k = 1; k <= 80; k++) begin
      sck_h[k]  = SCK;
      ssel_h[k] = SSEL;
      rdy_h[k]  = tx_ready;
      busy_h[k] = busy;
      @(negedge clk);
    end
    check("t1_sck_k4",    sck_h[4],   1'b0);
    check("t1_sck_k5",    sck_h[5],   1'b1);
    check("t1_sck_k64",   sck_h[64],  1'b1);
    check("t1_sck_k65",   sck_h[65],  1'b0);
    check("t1_ssel_k68",  ssel_h[68], 1'b0);
    check("t1_ssel_k69",  ssel_h[69], 1'b1);
    check("t1_ready_k72", rdy_h[72],  1'b0);
    check("t1_ready_k73", rdy_h[73],  1'b1);
    check("t1_busy_k72",  busy_h[72], 1'b1);
    check("t1_busy_k73",  busy_h[73], 1'b0);
    check("t1_rises",     rises - base, 8);
    check("t1_byte",      get_byte(base), 8'hA5);

    // 2: two-byte frame AA, 55
    base = rises; sf = ssel_falls; sr = ssel_rises;
    send(8'hAA, 1'b0, "t2a");
    send(8'h55, 1'b1, "t2b");
    wait_idle("t2");
    check("t2_rises",      rises - base, 16);
    check("t2_byte0",      get_byte(base),     8'hAA);
    check("t2_byte1",      get_byte(base + 8), 8'h55);
    check("t2_ssel_falls", ssel_falls - sf, 1);
    check("t2_ssel_rises", ssel_rises - sr, 1);
    check("t2_low_in_byte", low_q[base + 1], CLK_DIV);
    check("t2_low_between", low_q[base + 8], CLK_DIV + 1);

    // 3: stall in GAP for 100 cycles
    base = rises; sf = ssel_falls;
    send(8'h01, 1'b0, "t3a");
    wait_ready("t3_gap");
    viol = 0;
    repeat (100) begin
      if (SSEL !== 1'b0 || SCK !== 1'b0) viol++;
      @(negedge clk);
    end
    send(8'h80, 1'b1, "t3b");
    wait_idle("t3");
    check("t3_stall_viol", viol, 0);
    check("t3_rises",      rises - base, 16);
    check("t3_byte0",      get_byte(base),     8'h01);
    check("t3_byte1",      get_byte(base + 8), 8'h80);
    check("t3_ssel_falls", ssel_falls - sf, 1);

    // 4: reset at the 3rd SCK rise of FF, then a clean 3C
    base = rises;
    send(8'hFF, 1'b1, "t4a");
    wait_rises(base + 3, "t4");
    #1 rst = 1'b1;
    #1;
    check("t4_rst_ssel",  SSEL,     1'b1);
    check("t4_rst_sck",   SCK,      1'b0);
    check("t4_rst_mosi",  MOSI,     1'b0);
    check("t4_rst_ready", tx_ready, 1'b0);
    check("t4_rst_busy",  busy,     1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("t4_rel_ready0", tx_ready, 1'b0);
    @(negedge clk);
    check("t4_rel_ready1", tx_ready, 1'b1);
    base = rises;
    send(8'h3C, 1'b1, "t4b");
    wait_idle("t4");
    check("t4_rises", rises - base, 8);
    check("t4_byte",  get_byte(base), 8'h3C);

    // 5: tx_valid held high and tx_data/tx_last changed mid-byte
    base = rises; sr = ssel_rises;
    @(negedge clk);
    tx_data  = 8'h96;
    tx_last  = 1'b1;
    tx_valid = 1'b1;
    wait_ready("t5");
    @(posedge clk);
    wait_rises(base + 4, "t5");
    tx_data = 8'h69;
    tx_last = 1'b0;
    n = 0;
    while (SSEL !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("t5_ssel_timeout", 32'(n < BOUND), 32'd1);
    tx_valid = 1'b0;
    wait_idle("t5");
    check("t5_rises",      rises - base, 8);
    check("t5_byte",       get_byte(base), 8'h96);
    check("t5_ssel_rises", ssel_rises - sr, 1);

`ifdef SPI_TX_MISO_CAPTURE_EN
    // 6: MISO capture of C3 while sending 00
    begin
      int   pulses  = 0;
      int   at_fall = 0;
      logic prev_sck;
      miso_pat  = 8'hC3;
      miso_base = rises;
      base      = rises;
      send(8'h00, 1'b1, "t6");
      prev_sck = SCK;
      repeat (100) begin
        if (rx_valid === 1'b1) begin
          pulses++;
          if (SCK === 1'b0 && prev_sck === 1'b1 && rises - base == 8) at_fall++;
        end
        prev_sck = SCK;
        @(negedge clk);
      end
      wait_idle("t6");
      check("t6_rx_pulses",  pulses,  1);
      check("t6_rx_at_fall", at_fall, 1);
      check("t6_rx_data",    rx_data, 8'hC3);
      check("t6_tx_byte",    get_byte(base), 8'h00);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
